// File: rtl/rms_result_streamer_pkg.sv
// Shared constants, pointer-width helper and tagged result word for the RMS result streamer.
package rms_result_streamer_pkg;

  localparam int DEF_WIDTH_DATA = 28;
  localparam int DEF_TAG_W      = 4;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_CNT_W      = 16;

  // Smallest w with 2**w >= n; at least 1 so a 2-entry FIFO still gets a pointer bit.
  function automatic int ptr_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  typedef struct packed {
    logic [DEF_TAG_W-1:0]      tag;
    logic [DEF_WIDTH_DATA-1:0] rms;
  } tagged_word_t;

endpackage

// File: rtl/rms_result_streamer_if.sv
// Tagged-result stream toward the HPS reader.
// Handshake: a word transfers on a rising clk edge where tx_valid && tx_ready; the master keeps
// tx_valid high and tx_data stable until that transfer (or a flush), and tx_ready may change freely.
interface rms_result_streamer_if #(
  parameter int W = rms_result_streamer_pkg::DEF_TAG_W + rms_result_streamer_pkg::DEF_WIDTH_DATA
) ();
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/rms_tag_fifo.sv
// Generic synchronous FIFO: async active-low reset, synchronous clear, concurrent push/pop, level.
module rms_tag_fifo
  import rms_result_streamer_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic                       full,
  output logic [ptr_width(DEPTH):0]  level
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset; consumers mask the head with empty.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

endmodule

// File: rtl/rms_result_streamer.sv
// Tags each RMS result with a wrapping sequence number, buffers it, and streams it to the HPS reader.
module rms_result_streamer
  import rms_result_streamer_pkg::*;
#(
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int TAG_W      = DEF_TAG_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH_DATA-1:0]     rms,
  input  logic                      rms_strobe,
  input  logic                      flush,
  rms_result_streamer_if.master     tx,
  output logic [ptr_width(DEPTH):0] fill_level,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_count
);

  localparam int WORD_W = TAG_W + WIDTH_DATA;

  logic [TAG_W-1:0]  tag;
  logic [WORD_W-1:0] word_in;
  logic [WORD_W-1:0] head;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  // flush outranks everything; a pop frees a slot for a push in the same cycle.
  assign pop     = tx.tx_valid && tx.tx_ready && !flush;
  assign push    = rms_strobe && !flush && (!full || pop);
  assign drop    = rms_strobe && !flush && full && !pop;
  assign word_in = {tag, rms};

  rms_tag_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (push),
    .pop     (pop),
    .wdata   (word_in),
    .rdata   (head),
    .empty   (empty),
    .full    (full),
    .level   (fill_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      tag        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      // Tag advances on stored and dropped results alike so gaps show up downstream.
      if (rms_strobe) tag <= tag + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign tx.tx_valid = !empty;
  assign tx.tx_data  = empty ? '0 : head;

endmodule

// File: tb/tb_rms_result_streamer.sv
// Self-checking bench: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_rms_result_streamer;
  import rms_result_streamer_pkg::*;

  localparam int WD = DEF_WIDTH_DATA;
  localparam int TW = DEF_TAG_W;
  localparam int DP = DEF_DEPTH;
  localparam int CW = DEF_CNT_W;

  logic          clk;
  logic          reset_n;
  logic [WD-1:0] rms;
  logic          rms_strobe;
  logic          flush;
  logic [2:0]    fill_level;
  logic          overflow;
  logic [CW-1:0] drop_count;

  rms_result_streamer_if #(.W(TW + WD)) tx_if ();

  rms_result_streamer #(
    .WIDTH_DATA (WD),
    .TAG_W      (TW),
    .DEPTH      (DP),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rms        (rms),
    .rms_strobe (rms_strobe),
    .flush      (flush),
    .tx         (tx_if.master),
    .fill_level (fill_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queue of tagged words, tag counter, sticky overflow, saturating drops
  logic [31:0] exp_q[$];
  int          m_tag;
  bit          m_ovf;
  int          m_drop;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_tag  = 0;
      m_ovf  = 0;
      m_drop = 0;
    end else if (flush) begin
      exp_q.delete();
      m_tag  = 0;
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      tagged_word_t tw;
      if (exp_q.size() > 0 && tx_if.tx_ready) void'(exp_q.pop_front());
      if (rms_strobe) begin
        if (exp_q.size() < DP) begin
          tw.tag = TW'(m_tag);
          tw.rms = rms;
          exp_q.push_back(tw);
        end else begin
          m_ovf = 1;
          if (m_drop < (1 << CW) - 1) m_drop++;
        end
        m_tag = (m_tag + 1) % (1 << TW);
      end
    end
  end

  // compare process on the inactive edge
  always @(negedge clk) begin
    chk("cyc_valid", {31'd0, tx_if.tx_valid}, {31'd0, exp_q.size() > 0});
    chk("cyc_data", tx_if.tx_data, (exp_q.size() > 0) ? exp_q[0] : 32'd0);
    chk("cyc_fill", {29'd0, fill_level}, exp_q.size());
    chk("cyc_ovf", {31'd0, overflow}, {31'd0, m_ovf});
    chk("cyc_drop", {16'd0, drop_count}, m_drop);
  end

  // driver: hold inputs for one edge, then return to idle 1 unit after it
  task automatic tick(input bit s, input logic [WD-1:0] d, input bit r, input bit f);
    rms_strobe      = s;
    rms             = d;
    tx_if.tx_ready  = r;
    flush           = f;
    @(posedge clk);
    #1;
    rms_strobe      = 1'b0;
    tx_if.tx_ready  = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic chk_state(input string name, input bit v, input int fl, input bit o, input int dc);
    chk({name, "_valid"}, {31'd0, tx_if.tx_valid}, {31'd0, v});
    chk({name, "_fill"}, {29'd0, fill_level}, fl);
    chk({name, "_ovf"}, {31'd0, overflow}, {31'd0, o});
    chk({name, "_drop"}, {16'd0, drop_count}, dc);
  endtask

  logic [WD-1:0] d;

  initial begin
    reset_n        = 1'b0;
    rms            = '0;
    rms_strobe     = 1'b0;
    flush          = 1'b0;
    tx_if.tx_ready = 1'b0;
    #3;
    chk_state("reset", 0, 0, 0, 0);
    chk("reset_data", tx_if.tx_data, 32'd0);
    #9 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single result, held while not ready, then popped
    tick(1, 28'h0ABCDEF, 0, 0);
    chk_state("single", 1, 1, 0, 0);
    chk("single_data", tx_if.tx_data, 32'h00ABCDEF);
    for (int i = 0; i < 10; i++) begin
      tick(0, '0, 0, 0);
      chk("hold_data", tx_if.tx_data, 32'h00ABCDEF);
    end
    tick(0, '0, 1, 0);
    chk_state("popped", 0, 0, 0, 0);

    // overflow: four stored, fifth dropped, drain shows tags 0..3, next tag is 5
    tick(0, '0, 0, 1);
    for (int i = 1; i <= 5; i++) tick(1, WD'(i), 0, 0);
    chk_state("ovf", 1, 4, 1, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain", tx_if.tx_data, {TW'(i), WD'(i + 1)});
      tick(0, '0, 1, 0);
    end
    chk("drained_fill", {29'd0, fill_level}, 0);
    tick(1, 28'd6, 0, 0);
    chk("gap_tag", {28'd0, tx_if.tx_data[31:28]}, 5);
    tick(0, '0, 1, 0);

    // full with a pop and a strobe in the same cycle: no drop, new entry lands last
    tick(0, '0, 0, 1);
    for (int i = 1; i <= 4; i++) tick(1, WD'(i), 0, 0);
    tick(1, 28'd9, 1, 0);
    chk_state("full_pop", 1, 4, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("full_pop_drain", tx_if.tx_data, (i == 4) ? {4'd4, 28'd9} : {TW'(i), WD'(i + 1)});
      tick(0, '0, 1, 0);
    end

    // 20 results drained immediately: tag wraps 15 -> 0
    tick(0, '0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      d = (i == 10) ? 28'h7FFFFFF : WD'($urandom());
      tick(1, d, 0, 0);
      chk("wrap_seq", tx_if.tx_data, {TW'(i % 16), d});
      tick(0, '0, 1, 0);
    end

    // flush with a strobe while holding 3 and overflow set
    tick(0, '0, 0, 1);
    for (int i = 1; i <= 5; i++) tick(1, WD'(i), 0, 0);
    tick(0, '0, 1, 0);
    chk_state("pre_flush", 1, 3, 1, 1);
    tick(1, 28'd7, 0, 1);
    chk_state("flush", 0, 0, 0, 0);
    tick(1, 28'd8, 0, 0);
    chk("flush_tag0", tx_if.tx_data, {4'd0, 28'd8});
    tick(0, '0, 1, 0);

    // asynchronous reset between edges while holding 2
    tick(1, 28'd11, 0, 0);
    tick(1, 28'd12, 0, 0);
    #3 reset_n = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 0, 0);
    chk("async_rst_data", tx_if.tx_data, 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    tick(1, 28'h0000123, 0, 0);
    chk("post_rst_tag0", tx_if.tx_data, {4'd0, 28'h0000123});

    // random traffic checked by the per-cycle compare
    for (int i = 0; i < 600; i++) begin
      tick(bit'($urandom_range(0, 1)), WD'($urandom()),
           $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
    end
    for (int i = 0; i < 6; i++) tick(0, '0, 1, 0);
    chk("final_fill", {29'd0, fill_level}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
